hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sits in ID and detects load-use and branch-operand hazards, then sequences multi-cycle stalls with a small FSM and bubble counter. It drives the select input of the ID-stage control-zeroing mux (1 = pass decoded control, 0 = inject bubble), plus the PC and IF/ID write enables, the IF/ID flush and a global pipeline hold for memory wait states.

## Interface
- `REG_W`, 5, register-specifier width
- `CNT_W`, 2, bubble-counter width (max 2 bubbles required)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `id_rs`, `id_rt`  in  REG_W  source specifiers of the instruction in ID
- `id_uses_rs`, `id_uses_rt`  in  1  the ID instruction reads rs / rt
- `id_branch`  in  1  ID instruction is a branch resolved in ID
- `id_branch_taken`  in  1  branch comparison result in ID
- `ex_mem_read`  in  1  EX instruction is a load
- `ex_reg_write`  in  1  EX instruction writes a register
- `ex_dest`  in  REG_W  EX destination register
- `mem_mem_read`  in  1  MEM instruction is a load
- `mem_dest`  in  REG_W  MEM destination register
- `mem_wait`  in  1  data memory not ready; freeze the whole pipeline
- `pc_write`  out  1  PC update enable
- `ifid_write`  out  1  IF/ID register enable
- `ctrl_sel`  out  1  control-mux select (0 = bubble)
- `ifid_flush`  out  1  clear IF/ID to NOP
- `pipe_hold`  out  1  hold ID/EX, EX/MEM and MEM/WB registers
- `stall_cycles`  out  16  bubble counter (only with `HAZARD_STATS_EN`)

## Operation
- Match(a) = `a != 0` and ((`id_uses_rs` and `a == id_rs`) or (`id_uses_rt` and `a == id_rt`)). Register $0 never causes a hazard.
- The bubble need `n` is the max of these terms (0 if none):
  - load-use: `ex_mem_read` and Match(`ex_dest`) → 1
  - branch on ALU result: `id_branch` and `ex_reg_write` and not `ex_mem_read` and Match(`ex_dest`) → 1
  - branch on EX load: `id_branch` and `ex_mem_read` and Match(`ex_dest`) → 2
  - branch on MEM load: `id_branch` and `mem_mem_read` and Match(`mem_dest`) → 1
- States:
  - RUN, with `cnt` = 0:
    - If `n` = 0, the controller passes: `pc_write` = `ifid_write` = `ctrl_sel` = 1.
    - If `n` > 0, the controller stalls this cycle: `pc_write` = `ifid_write` = `ctrl_sel` = 0. It sets `cnt` <= `n`-1 and moves to STALL if `n`-1 > 0.
  - STALL:
    - Outputs are stalled, and the hazard terms are ignored.
    - `cnt` decrements each cycle. When `cnt` reaches 1, the next state is RUN.
    - Detection re-evaluates in the first RUN cycle.
- Flush:
  - `ifid_flush` = `id_branch` and `id_branch_taken` and `ctrl_sel` = 1 and not `mem_wait`.
  - A branch is never flushed while it is stalled.
- `mem_wait` has top priority:
  - `pipe_hold` = 1, `pc_write` = `ifid_write` = 0, `ctrl_sel` = 1 (no bubble, all stages frozen), `ifid_flush` = 0.
  - State and `cnt` are frozen, and no new detection is taken.
- `pipe_hold` = `mem_wait` (registered decode not allowed; same-cycle).

## Timing
- Outputs are combinational from current inputs, state and `cnt`. Hazard-to-bubble latency is 0 cycles, and the first bubble is issued in the detecting cycle.
- Stall length is exactly `n` cycles, not counting `mem_wait` cycles.
- Reset value (while `reset` = 1): state RUN, `cnt` = 0, `stall_cycles` = 0.
  - Outputs during reset: `pc_write` = `ifid_write` = 0, `ctrl_sel` = 0, `ifid_flush` = 0, `pipe_hold` = 0.
  - The first cycle after deassertion is RUN.
- Reset mid-STALL aborts the stall immediately, and the next cycle evaluates fresh.
- `mem_wait` asserted in the same cycle a hazard is detected: hold wins. The hazard is detected when `mem_wait` drops, because the inputs are unchanged under hold.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_cycles` exists.
  - It is a 16-bit saturating counter that increments on every cycle with `ctrl_sel` = 0 outside reset.
  - It holds at 16'hFFFF and is cleared only by `reset`.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Load-use: EX `lw` with `ex_dest` = 8, ID `add` with rs = 8 → one cycle with `ctrl_sel` = `pc_write` = `ifid_write` = 0, then RUN passes.
- $0 filter: EX `lw` with `ex_dest` = 0, ID rs = 0 → no stall, `ctrl_sel` = 1.
- Branch after load: `id_branch` = 1, EX `lw` with `ex_dest` = 9, ID rt = 9, inputs held → exactly 2 bubble cycles, then `ctrl_sel` = 1. With `id_branch_taken` = 1, `ifid_flush` = 1 only in the third cycle.
- Branch on ALU result, EX dest = 3 matching rs → 1 bubble. Branch on MEM load, dest = 3 → 1 bubble.
- `mem_wait` = 1 for 3 cycles during the second bubble of a 2-bubble stall → `pipe_hold` = 1, `ctrl_sel` = 1, `cnt` frozen. The stall completes 1 cycle after `mem_wait` drops.
- Reset asserted in STALL → outputs at reset values. After release, RUN with no hazard gives `ctrl_sel` = 1. With `HAZARD_STATS_EN`, `stall_cycles` = 0 after reset and equals the total bubble cycles afterward.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_stall_ctrl : ID-stage load-use / branch-operand hazard detection with
//                     multi-cycle stall sequencing and memory-wait pipeline hold.
//                     Optional macro HAZARD_STATS_EN adds the stall_cycles counter.
// Rev 1.0
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wait,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ctrl_sel,
  output logic             ifid_flush,
  output logic             pipe_hold
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] need;
  logic             ex_match;
  logic             mem_match;
  logic             stalled;

  // Register $0 is hard-wired zero, so it never creates a dependency.
  assign ex_match  = (ex_dest != '0) &&
                     ((id_uses_rs && (ex_dest == id_rs)) || (id_uses_rt && (ex_dest == id_rt)));
  assign mem_match = (mem_dest != '0) &&
                     ((id_uses_rs && (mem_dest == id_rs)) || (id_uses_rt && (mem_dest == id_rt)));

  always_comb begin
    need = '0;
    if (ex_mem_read && ex_match)
      need = CNT_W'(1);
    if (id_branch && ex_reg_write && !ex_mem_read && ex_match)
      need = CNT_W'(1);
    if (id_branch && mem_mem_read && mem_match)
      need = CNT_W'(1);
    if (id_branch && ex_mem_read && ex_match)
      need = CNT_W'(2);
  end

  assign stalled = (state == STALL) || (need != '0);

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ctrl_sel   = 1'b0;
    ifid_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (reset) begin
      ctrl_sel = 1'b0;
    end else if (mem_wait) begin
      // Freeze everything without injecting a bubble.
      pipe_hold = 1'b1;
      ctrl_sel  = 1'b1;
    end else if (!stalled) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ctrl_sel   = 1'b1;
      ifid_flush = id_branch && id_branch_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!mem_wait) begin
      case (state)
        RUN: begin
          if (need != '0) begin
            cnt <= need - CNT_W'(1);
            if (need > CNT_W'(1))
              state <= STALL;
          end
        end
        STALL: begin
          if (cnt <= CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (!ctrl_sel && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl : directed scenarios plus randomized traffic checked
//                        against a remaining-bubble reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest;
  logic       id_uses_rs, id_uses_rt, id_branch, id_branch_taken;
  logic       ex_mem_read, ex_reg_write, mem_mem_read, mem_wait;
  logic       pc_write, ifid_write, ctrl_sel, ifid_flush, pipe_hold;
  logic [4:0] outs;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int tests = 0;
  int fails = 0;
  int m_rem = 0;    // bubbles still owed by the reference model
  int m_count = 0;  // expected bubble-cycle total since reset

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_W(5), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_branch_taken(id_branch_taken),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
    .mem_mem_read(mem_mem_read), .mem_dest(mem_dest), .mem_wait(mem_wait),
    .pc_write(pc_write), .ifid_write(ifid_write), .ctrl_sel(ctrl_sel),
    .ifid_flush(ifid_flush), .pipe_hold(pipe_hold)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  assign outs = {pc_write, ifid_write, ctrl_sel, ifid_flush, pipe_hold};

  function automatic bit reads(input logic [4:0] a);
    return (a != 0) && ((id_uses_rs && a == id_rs) || (id_uses_rt && a == id_rt));
  endfunction

  function automatic int need_n();
    int n = 0;
    if (ex_mem_read && reads(ex_dest)) n = 1;
    if (id_branch && ex_reg_write && !ex_mem_read && reads(ex_dest)) n = 1;
    if (id_branch && mem_mem_read && reads(mem_dest)) n = 1;
    if (id_branch && ex_mem_read && reads(ex_dest)) n = 2;
    return n;
  endfunction

  // Expected {pc_write, ifid_write, ctrl_sel, ifid_flush, pipe_hold}
  function automatic logic [4:0] model_out();
    if (reset) return 5'b00000;
    if (mem_wait) return 5'b00101;
    if (m_rem > 0 || need_n() > 0) return 5'b00000;
    return {3'b111, id_branch && id_branch_taken, 1'b0};
  endfunction

  task automatic tick();
    logic [4:0] e;
    int n;
    e = model_out();
    @(posedge clk);
    if (reset) begin
      m_rem = 0;
      m_count = 0;
    end else begin
      if (!e[2] && m_count < 65535) m_count++;
      if (!mem_wait) begin
        if (m_rem > 0) m_rem--;
        else begin
          n = need_n();
          if (n > 0) m_rem = n - 1;
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_dest = 0; mem_dest = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_branch = 0; id_branch_taken = 0;
    ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0; mem_wait = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    ex_mem_read = 1; ex_dest = 8; id_uses_rs = 1; id_rs = 8; mem_wait = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (outs !== 5'b00000) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, outs, 5'b00000);
      end
      tick();
    end
`ifdef HAZARD_STATS_EN
    tests++;
    if (stall_cycles !== 16'd0) begin
      fails++;
      $display("FAIL reset_stats: got %0d expected 0", stall_cycles);
    end
`endif
    clear_inputs();
    reset = 0;
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 8; id_uses_rs = 1; id_rs = 8; id_rt = 4;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL load_use_bubble: got %b expected 00000", outs); end
    tick();
    ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0; mem_mem_read = 1; mem_dest = 8;
    @(negedge clk); tests++;
    if (outs !== 5'b11100) begin fails++; $display("FAIL load_use_resume: got %b expected 11100", outs); end
    tick();
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    ex_mem_read = 1; ex_dest = 0; id_uses_rs = 1; id_rs = 0; id_branch = 1;
    @(negedge clk); tests++;
    if (outs !== 5'b11100) begin fails++; $display("FAIL zero_reg_filter: got %b expected 11100", outs); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_load();
    id_branch = 1; id_branch_taken = 1; id_uses_rt = 1; id_rt = 9;
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 9;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL br_load_bubble1: got %b expected 00000", outs); end
    tick();
    // The load advances to MEM; the pending stall must ignore that term.
    ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0; mem_mem_read = 1; mem_dest = 9;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL br_load_bubble2: got %b expected 00000", outs); end
    tick();
    mem_mem_read = 0; mem_dest = 0;
    @(negedge clk); tests++;
    if (outs !== 5'b11110) begin fails++; $display("FAIL br_load_flush: got %b expected 11110", outs); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_single();
    id_branch = 1; id_uses_rs = 1; id_rs = 3; ex_reg_write = 1; ex_dest = 3;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL br_alu_bubble: got %b expected 00000", outs); end
    tick();
    ex_reg_write = 0; ex_dest = 0;
    @(negedge clk); tests++;
    if (outs !== 5'b11100) begin fails++; $display("FAIL br_alu_resume: got %b expected 11100", outs); end
    tick();
    mem_mem_read = 1; mem_dest = 3;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL br_mem_bubble: got %b expected 00000", outs); end
    tick();
    mem_mem_read = 0; mem_dest = 0;
    @(negedge clk); tests++;
    if (outs !== 5'b11100) begin fails++; $display("FAIL br_mem_resume: got %b expected 11100", outs); end
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    id_branch = 1; id_uses_rs = 1; id_rs = 9; ex_mem_read = 1; ex_dest = 9;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL mw_first_bubble: got %b expected 00000", outs); end
    tick();
    ex_mem_read = 0; ex_dest = 0; mem_mem_read = 1; mem_dest = 9; mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tests++;
      if (outs !== 5'b00101) begin fails++; $display("FAIL mw_hold cycle %0d: got %b expected 00101", i, outs); end
      tick();
    end
    mem_wait = 0;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL mw_second_bubble: got %b expected 00000", outs); end
    tick();
    mem_mem_read = 0; mem_dest = 0;
    @(negedge clk); tests++;
    if (outs !== 5'b11100) begin fails++; $display("FAIL mw_resume: got %b expected 11100", outs); end
    tick();
    // Hazard and hold together: hold wins, hazard taken once hold drops.
    ex_mem_read = 1; ex_dest = 5; id_uses_rs = 1; id_rs = 5; id_branch = 0; mem_wait = 1;
    @(negedge clk); tests++;
    if (outs !== 5'b00101) begin fails++; $display("FAIL mw_hazard_hold: got %b expected 00101", outs); end
    tick();
    mem_wait = 0;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL mw_hazard_late: got %b expected 00000", outs); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_in_stall();
    id_branch = 1; id_uses_rt = 1; id_rt = 6; ex_mem_read = 1; ex_dest = 6;
    tick();
    reset = 1;
    @(negedge clk); tests++;
    if (outs !== 5'b00000) begin fails++; $display("FAIL stall_reset: got %b expected 00000", outs); end
    tick();
    reset = 0;
    clear_inputs();
    @(negedge clk); tests++;
    if (outs !== 5'b11100) begin fails++; $display("FAIL stall_reset_release: got %b expected 11100", outs); end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      mem_wait = ($urandom_range(0, 5) == 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_dest = 5'($urandom_range(0, 3)); mem_dest = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_branch = 1'($urandom); id_branch_taken = 1'($urandom);
      ex_mem_read = 1'($urandom); ex_reg_write = 1'($urandom);
      mem_mem_read = 1'($urandom);
      @(negedge clk);
      e = model_out();
      tests++;
      if (outs !== e) begin
        fails++;
        $display("FAIL random_cycle %0d: got %b expected %b", i, outs, e);
      end
      tick();
    end
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_stats();
`ifdef HAZARD_STATS_EN
    @(negedge clk); tests++;
    if (stall_cycles !== 16'(m_count)) begin
      fails++;
      $display("FAIL stats_total: got %0d expected %0d", stall_cycles, m_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_load();
    test_branch_single();
    test_mem_wait();
    test_reset_in_stall();
    test_stats();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
